// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches 32-bit words from instruction
// memory over a req/ack handshake and hands them to decode over valid/ready.
//
// Handshakes:
//   imem side : imem_req/imem_addr are decoded from registered state only.
//               A word is taken in any cycle where imem_req=1 and imem_ack=1.
//               imem_ack is ignored whenever imem_req=0.
//   decode side: inst/ctl_op/pc are held stable while inst_valid=1 and
//               inst_ready=0. A transfer (accept) happens in a cycle where
//               inst_valid=1 and inst_ready=1. take_branch is used only then.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  ctl_op,
  output logic [31:0] pc,
  input  logic        take_branch,
  output logic        fetch_fault,
  output logic [15:0] fetch_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Unaligned reset vectors are forced onto a word boundary.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  // Counter value seen in the last WAIT cycle before the fault fires.
  localparam logic [7:0]  TIMEOUT_LAST     = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_next;
  logic        armed_q;
  logic [7:0]  to_cnt_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic        fetch_fault_q;
  logic [15:0] fetch_count_q;

  logic        capture;
  logic        accept;
  logic        timeout;
  logic [31:0] pc_seq;
  logic [31:0] branch_off;
  logic [31:0] pc_next;

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state decode, memory request and per-cycle strobes.
  // After reset the FSM sits one idle cycle in FETCH with imem_req=0
  // (armed_q low), so a stale ack from the abandoned transaction is dropped.
  always_comb begin
    state_next = state_q;
    imem_req   = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (armed_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            capture    = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          capture    = 1'b1;
          state_next = ST_ISSUE;
        end else if (to_cnt_q == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          state_next = ST_HALT;
        end
      end
      ST_ISSUE: begin
        if (inst_valid_q && inst_ready) begin
          accept     = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Sequential and branch targets; all arithmetic wraps modulo 2^32.
  always_comb begin
    pc_seq     = pc_q + 32'd4;
    branch_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    pc_next    = take_branch ? (pc_seq + branch_off) : pc_seq;
  end

  // Datapath registers: PC, instruction latch, timeout counter, fault, count.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q       <= 1'b0;
      to_cnt_q      <= 8'd0;
      pc_q          <= RESET_PC_ALIGNED;
      inst_q        <= 32'd0;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      armed_q <= 1'b1;

      if (state_q == ST_WAIT && !imem_ack) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end else begin
        to_cnt_q <= 8'd0;
      end

      if (capture) begin
        inst_q       <= imem_rdata;
        inst_valid_q <= 1'b1;
      end

      if (accept) begin
        inst_valid_q <= 1'b0;
        pc_q         <= pc_next;
        if (fetch_count_q != 16'hFFFF) begin
          fetch_count_q <= fetch_count_q + 16'd1;
        end
      end

      if (timeout) begin
        fetch_fault_q <= 1'b1;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign ctl_op      = inst_q[31:26];
  assign pc          = pc_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Produces the instruction stream consumed by the processor control unit and datapath.
- Holds the program counter and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents the fetched instruction and its 6-bit opcode field to decode through a valid/ready handshake.
- Updates the PC sequentially, or to a branch target when decode/execute reports a taken BEQ.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ACK_TIMEOUT, 15, max cycles waiting for imem_ack before fault (1..255)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  byte address of fetch (= pc)
imem_ack  in  1  memory has valid imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
inst_valid  out  1  inst/ctl_op valid for decode
inst_ready  in  1  decode accepts instruction this cycle
inst  out  32  latched instruction word
ctl_op  out  6  inst[31:26], opcode to control unit
pc  out  32  address of instruction currently held/fetched
take_branch  in  1  branch AND zero for the held instruction; sampled only on accept
fetch_fault  out  1  sticky ack-timeout fault
fetch_count  out  16  instructions accepted since reset

Behaviour:
- Reset (rst high at an edge, any state, including mid-wait): state=FETCH, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, ctl_op=0, fetch_fault=0, fetch_count=0, timeout counter=0. A pending memory transaction is abandoned. Any ack arriving after reset and before the next request is ignored.
- FSM states: FETCH, WAIT, ISSUE, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc on this cycle.
  - If imem_ack is also high, capture imem_rdata and go to ISSUE (1-cycle fetch).
  - Otherwise go to WAIT.
- WAIT:
  - imem_req held 1 and imem_addr stable.
  - imem_ack=1: capture imem_rdata into inst, clear timeout counter, go to ISSUE.
  - Otherwise increment timeout counter. When the counter reaches ACK_TIMEOUT with no ack: set fetch_fault=1, imem_req=0, go to HALT.
- ISSUE:
  - imem_req=0, inst_valid=1.
  - inst, ctl_op and pc are held stable while inst_valid=1 and inst_ready=0.
  - Accept occurs when inst_valid=1 and inst_ready=1.
- On accept:
  - fetch_count increments, saturating at 16'hFFFF.
  - If take_branch=1: pc <= pc + 4 + (sign-extended inst[15:0] << 2). Otherwise pc <= pc + 4.
  - All arithmetic is modulo 2^32; wrap past 32'hFFFF_FFFC returns to 0 with no flag.
  - inst_valid drops next cycle; state goes to FETCH.
  - Minimum throughput is one instruction per 2 cycles (FETCH with immediate ack, then ISSUE accepted).
- take_branch is ignored in every cycle that is not an accept.
- imem_ack outside FETCH/WAIT is ignored; inst is not overwritten.
- HALT: imem_req=0, inst_valid=0, and pc frozen at the faulting address. Exit only via rst.
- imem_addr low two bits are always 0. RESET_PC must be word-aligned; an unaligned parameter is truncated to [31:2],2'b00.
- Outputs are registered except imem_req and imem_addr, which are decoded from state/pc with no combinational path from inputs.

Test Plan:
- Reset then imem_ack tied high, inst_ready high, rdata=32'h8C08_0004 (LW) -> imem_addr sequence 0,4,8,...; ctl_op=6'b100011; inst_valid pulses every 2nd cycle; fetch_count=5 after 5 accepts.
- Ack delayed 3 cycles per fetch -> imem_req high for 4 consecutive cycles with addr stable; exactly one accept per fetch; inst unchanged by spurious ack during ISSUE.
- BEQ 32'h1000_FFFF at pc=0x100, take_branch=1 on accept -> next imem_addr=0x100; same instruction with take_branch=0 -> 0x104; take_branch pulsed while inst_ready=0 -> no effect.
- inst_ready held low 10 cycles in ISSUE -> inst, ctl_op, pc constant and no new imem_req; release -> pc advances by 4 once.
- imem_ack never asserted -> fetch_fault=1 exactly ACK_TIMEOUT cycles after entering WAIT, imem_req=0 thereafter; rst -> fetch_fault=0, pc=RESET_PC.
- RESET_PC=32'hFFFF_FFFC, sequential accept -> pc wraps to 0; rst asserted during WAIT -> next cycle imem_req=0, inst_valid=0, pc=RESET_PC.
